// File: rtl/shl_iter.sv
// rtl/shl_iter.sv - multi-cycle 16-bit logical-left / rotate-left shifter with valid/ready handshake
module shl_iter #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SHW-1:0] STEP_AMT = SHW'(STEP);

    state_t             state;
    logic [WIDTH-1:0]   data_r;
    logic [SHW-1:0]     rem_r;
    logic               mode_r;

    logic [SHW-1:0]     k;
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   sll_v;
    logic [WIDTH-1:0]   rol_v;

    // Per-cycle step: never shift past the remaining amount; rotate via a doubled word
    always_comb begin
        k     = (rem_r < STEP_AMT) ? rem_r : STEP_AMT;
        dbl   = {data_r, data_r} << k;
        sll_v = data_r << k;
        rol_v = dbl[2*WIDTH-1:WIDTH];
    end

    // Control FSM; handshake flags are registered alongside the state they decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            data_r    <= '0;
            rem_r     <= '0;
            mode_r    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (flush) begin
            // Abort wins over accept and completion; data_r is deliberately kept
            state     <= IDLE;
            rem_r     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_r   <= in_data;
                        rem_r    <= in_amt;
                        mode_r   <= in_mode;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (in_amt == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data_r <= mode_r ? rol_v : sll_v;
                    rem_r  <= rem_r - k;
                    if (rem_r == k) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Return to IDLE first so no request is taken in the transfer cycle
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = data_r;

endmodule

// File: tb/tb_shl_iter.sv
// tb/tb_shl_iter.sv - randomized self-checking bench for shl_iter at STEP=1 and STEP=4
module tb_shl_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic        in_mode;
    logic        out_ready;

    logic [1:0]  ir;
    logic [1:0]  ov;
    logic [1:0]  bz;
    logic [15:0] od [2];

    int n_checks = 0;
    int n_fail   = 0;
    int steps [2] = '{1, 4};

    always #5 clk = ~clk;

    shl_iter #(.WIDTH(16), .SHW(4), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bz[0])
    );

    shl_iter #(.WIDTH(16), .SHW(4), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bz[1])
    );

    function automatic logic [15:0] ref_result(input logic [15:0] d, input int n, input logic m);
        int v;
        v = int'(d) * (1 << n);
        if (m)
            v = v + (int'(d) / (1 << (16 - n)));
        return 16'(v % 65536);
    endfunction

    task automatic test_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks += 4;
            if (ir[i] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready dut%0d: got %b expected 1", i, ir[i]); end
            if (ov[i] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid dut%0d: got %b expected 0", i, ov[i]); end
            if (bz[i] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d: got %b expected 0", i, bz[i]); end
            if (od[i] !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data dut%0d: got %h expected 0000", i, od[i]); end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One op on both units; early=1 holds out_ready high from accept, otherwise it is
    // released only after both results have been held for 'stall' extra cycles
    task automatic run_op(input logic [15:0] d, input int a, input logic m, input int stall, input bit early);
        int          lat [2];
        int          last;
        bit          exp_v;
        bit          exp_b;
        logic [15:0] exp_d;
        exp_d = ref_result(d, a, m);
        for (int i = 0; i < 2; i++)
            lat[i] = (a + steps[i] - 1) / steps[i];
        last = ((lat[0] > lat[1]) ? lat[0] : lat[1]) + 1 + stall;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (ir[i] !== 1'b1) begin n_fail++; $display("FAIL idle_before dut%0d: got %b expected 1", i, ir[i]); end
        end
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = 4'(a);
        in_mode   = m;
        out_ready = early;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_amt   = 4'($urandom);
        in_mode  = 1'($urandom);
        for (int c = 1; c <= last; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (early) begin
                    exp_v = (c == lat[i] + 1);
                    exp_b = (c <= lat[i] + 1);
                end else begin
                    exp_v = (c >= lat[i] + 1);
                    exp_b = 1'b1;
                end
                n_checks += 3;
                if (ov[i] !== exp_v) begin n_fail++; $display("FAIL out_valid dut%0d cyc%0d d=%h a=%0d m=%b: got %b expected %b", i, c, d, a, m, ov[i], exp_v); end
                if (bz[i] !== exp_b) begin n_fail++; $display("FAIL busy dut%0d cyc%0d: got %b expected %b", i, c, bz[i], exp_b); end
                if (ir[i] !== !exp_b) begin n_fail++; $display("FAIL in_ready dut%0d cyc%0d: got %b expected %b", i, c, ir[i], !exp_b); end
                if (c >= lat[i] + 1) begin
                    n_checks++;
                    if (od[i] !== exp_d) begin n_fail++; $display("FAIL out_data dut%0d cyc%0d d=%h a=%0d m=%b: got %h expected %h", i, c, d, a, m, od[i], exp_d); end
                end
            end
            if (c != last) @(negedge clk);
        end
        if (!early) begin
            out_ready = 1'b1;
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks += 3;
            if (ir[i] !== 1'b1) begin n_fail++; $display("FAIL idle_after dut%0d: got %b expected 1", i, ir[i]); end
            if (ov[i] !== 1'b0) begin n_fail++; $display("FAIL valid_after dut%0d: got %b expected 0", i, ov[i]); end
            if (od[i] !== exp_d) begin n_fail++; $display("FAIL data_after dut%0d: got %h expected %h", i, od[i], exp_d); end
        end
    endtask

    task automatic test_directed();
        run_op(16'h1234, 4,  1'b0, 0, 1'b1);
        run_op(16'h8001, 1,  1'b1, 0, 1'b1);
        run_op(16'hBEEF, 0,  1'b0, 0, 1'b1);
        run_op(16'hFFFF, 15, 1'b0, 3, 1'b0);
        run_op(16'h1234, 7,  1'b1, 0, 1'b1);
        run_op(16'h0001, 15, 1'b0, 1, 1'b0);
        run_op(16'h8000, 15, 1'b1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++)
            run_op(16'($urandom), int'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'hA5A5; in_amt = 4'd15; in_mode = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks += 4;
            if (ov[i] !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid dut%0d: got %b expected 0", i, ov[i]); end
            if (ir[i] !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready dut%0d: got %b expected 1", i, ir[i]); end
            if (bz[i] !== 1'b0) begin n_fail++; $display("FAIL arst_busy dut%0d: got %b expected 0", i, bz[i]); end
            if (od[i] !== 16'h0000) begin n_fail++; $display("FAIL arst_out_data dut%0d: got %h expected 0000", i, od[i]); end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (ov[i] !== 1'b0) begin n_fail++; $display("FAIL arst_no_valid dut%0d cyc%0d: got %b expected 0", i, c, ov[i]); end
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h0F0F; in_amt = 4'd14; in_mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 2; i++) begin
                n_checks += 3;
                if (ir[i] !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready dut%0d cyc%0d: got %b expected 1", i, c, ir[i]); end
                if (ov[i] !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid dut%0d cyc%0d: got %b expected 0", i, c, ov[i]); end
                if (bz[i] !== 1'b0) begin n_fail++; $display("FAIL flush_busy dut%0d cyc%0d: got %b expected 0", i, c, bz[i]); end
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        // flush together with a request in IDLE: the request must be dropped
        flush = 1'b1; in_valid = 1'b1; in_data = 16'h1111; in_amt = 4'd3;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks += 2;
            if (ir[i] !== 1'b1) begin n_fail++; $display("FAIL flush_idle_accept dut%0d: got %b expected 1", i, ir[i]); end
            if (bz[i] !== 1'b0) begin n_fail++; $display("FAIL flush_idle_busy dut%0d: got %b expected 0", i, bz[i]); end
        end
        run_op(16'hC3A5, 9, 1'b1, 0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; in_amt = '0; in_mode = 1'b0; out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_async_reset();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
